// File: rtl/fcp_credit_tracker.sv
// fcp_credit_tracker
//   Unpacks the FCP AXIS stream and keeps a per-VC credit table. Each entry
//   holds the latest credit limit (FCCL), the local transmitted-block count
//   and a valid flag. The transmit scheduler queries credit and gets the
//   answer one cycle later.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   s_axis_fcp_tdata/tvalid/tready
//                          FCP words: FCCL[31:0], QLEN[63:32], FCCR[95:64],
//                          VC[96 +: QUEUE_INDEX_WIDTH]
//   tx_valid/tx_vc/tx_blocks
//                          transmit events charged against a VC
//   query_valid/query_vc   credit query
//   resp_valid/resp_credit/resp_vc
//                          query response, one cycle after the query
//   init_done              table clear sweep finished
//   stat_fcp_accepted/dropped/stale
//                          FCP word disposition counters
module fcp_credit_tracker #(
  parameter int QUEUE_INDEX_WIDTH = 15,
  parameter int STAT_WIDTH        = 32,
  parameter int AXIS_WIDTH        = 128,
  parameter int NUM_VC            = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [AXIS_WIDTH-1:0]        s_axis_fcp_tdata,
  input  logic                         s_axis_fcp_tvalid,
  output logic                         s_axis_fcp_tready,
  input  logic                         tx_valid,
  input  logic [QUEUE_INDEX_WIDTH-1:0] tx_vc,
  input  logic [15:0]                  tx_blocks,
  input  logic                         query_valid,
  input  logic [QUEUE_INDEX_WIDTH-1:0] query_vc,
  output logic                         resp_valid,
  output logic [STAT_WIDTH-1:0]        resp_credit,
  output logic [QUEUE_INDEX_WIDTH-1:0] resp_vc,
  output logic                         init_done,
  output logic [STAT_WIDTH-1:0]        stat_fcp_accepted,
  output logic [STAT_WIDTH-1:0]        stat_fcp_dropped,
  output logic [STAT_WIDTH-1:0]        stat_fcp_stale
);

  localparam int IDX_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int VC_TOP = 96 + QUEUE_INDEX_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VC - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        init_idx_q;

  logic [STAT_WIDTH-1:0]   fccl_tab [NUM_VC];
  logic [STAT_WIDTH-1:0]   tx_tab   [NUM_VC];
  logic [NUM_VC-1:0]       ent_valid_q;

  logic                    vld_p1;
  logic [STAT_WIDTH-1:0]   credit_p1;
  logic [QUEUE_INDEX_WIDTH-1:0] vc_p1;

  function automatic logic vc_in_range(input logic [QUEUE_INDEX_WIDTH-1:0] vc);
    return 32'(vc) < 32'(NUM_VC);
  endfunction

  // New limit is stale when it lies behind the stored one in modular order.
  function automatic logic fccl_stale(input logic                  valid,
                                      input logic [STAT_WIDTH-1:0] new_fccl,
                                      input logic [STAT_WIDTH-1:0] old_fccl);
    logic signed [STAT_WIDTH-1:0] diff;
    diff = $signed(new_fccl - old_fccl);
    return valid && (diff < 0);
  endfunction

  // Modular difference, saturated at zero for invalid or overdrawn entries.
  function automatic logic [STAT_WIDTH-1:0] credit_sat(input logic                  valid,
                                                       input logic [STAT_WIDTH-1:0] fccl,
                                                       input logic [STAT_WIDTH-1:0] txc);
    logic signed [STAT_WIDTH-1:0] diff;
    diff = $signed(fccl - txc);
    if (!valid || diff < 0) return '0;
    return $unsigned(diff);
  endfunction

  // QLEN/FCCR and padding above the VC field carry nothing for this block.
  logic unused_fcp_bits;
  generate
    if (AXIS_WIDTH > VC_TOP) begin : g_pad
      assign unused_fcp_bits = ^{s_axis_fcp_tdata[95:32], s_axis_fcp_tdata[AXIS_WIDTH-1:VC_TOP]};
    end else begin : g_nopad
      assign unused_fcp_bits = ^s_axis_fcp_tdata[95:32];
    end
  endgenerate

  logic                         run;
  logic [QUEUE_INDEX_WIDTH-1:0] fcp_vc;
  logic [STAT_WIDTH-1:0]        fcp_fccl;
  logic [IDX_W-1:0]             fcp_idx, tx_idx, q_idx;
  logic                         fcp_fire, fcp_drop, fcp_stale, fcp_write, tx_fire, q_fire;

  assign run       = (state_q == ST_RUN);
  assign fcp_vc    = s_axis_fcp_tdata[96 +: QUEUE_INDEX_WIDTH];
  assign fcp_fccl  = STAT_WIDTH'(s_axis_fcp_tdata[31:0]);
  assign fcp_idx   = fcp_vc[IDX_W-1:0];
  assign tx_idx    = tx_vc[IDX_W-1:0];
  assign q_idx     = query_vc[IDX_W-1:0];
  assign fcp_fire  = run && s_axis_fcp_tvalid;
  assign fcp_drop  = fcp_fire && !vc_in_range(fcp_vc);
  assign fcp_stale = fcp_fire && vc_in_range(fcp_vc)
                     && fccl_stale(ent_valid_q[fcp_idx], fcp_fccl, fccl_tab[fcp_idx]);
  assign fcp_write = fcp_fire && vc_in_range(fcp_vc) && !fcp_stale;
  assign tx_fire   = run && tx_valid && vc_in_range(tx_vc);
  assign q_fire    = run && query_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    s_axis_fcp_tready = 1'b0;
    init_done         = 1'b0;
    case (state_q)
      ST_INIT: if (init_idx_q == LAST_IDX) state_d = ST_RUN;
      ST_RUN: begin
        s_axis_fcp_tready = 1'b1;
        init_done         = 1'b1;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 init_idx_q <= '0;
    else if (state_q == ST_INIT) init_idx_q <= init_idx_q + IDX_W'(1);
  end

  // p0: table update; reads above see the pre-edge contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid_q <= '0;
    end else if (state_q == ST_INIT) begin
      ent_valid_q[init_idx_q] <= 1'b0;
    end else if (fcp_write) begin
      ent_valid_q[fcp_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      fccl_tab[init_idx_q] <= '0;
      tx_tab[init_idx_q]   <= '0;
    end else begin
      if (fcp_write) fccl_tab[fcp_idx] <= fcp_fccl;
      if (tx_fire)   tx_tab[tx_idx]    <= tx_tab[tx_idx] + STAT_WIDTH'(tx_blocks);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fcp_accepted <= '0;
      stat_fcp_dropped  <= '0;
      stat_fcp_stale    <= '0;
    end else begin
      if (fcp_write) stat_fcp_accepted <= stat_fcp_accepted + 1'b1;
      if (fcp_drop)  stat_fcp_dropped  <= stat_fcp_dropped + 1'b1;
      if (fcp_stale) stat_fcp_stale    <= stat_fcp_stale + 1'b1;
    end
  end

  // p1: query response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      credit_p1 <= '0;
      vc_p1     <= '0;
    end else begin
      vld_p1 <= q_fire;
      if (q_fire) begin
        vc_p1     <= query_vc;
        credit_p1 <= vc_in_range(query_vc)
                     ? credit_sat(ent_valid_q[q_idx], fccl_tab[q_idx], tx_tab[q_idx])
                     : '0;
      end
    end
  end

  assign resp_valid  = vld_p1;
  assign resp_credit = credit_p1;
  assign resp_vc     = vc_p1;

endmodule

// File: tb/tb_fcp_credit_tracker.sv
module tb_fcp_credit_tracker;
  localparam int QW = 15;
  localparam int SW = 32;
  localparam int AW = 128;
  localparam int NV = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] s_axis_fcp_tdata = '0;
  logic          s_axis_fcp_tvalid = 1'b0;
  logic          s_axis_fcp_tready;
  logic          tx_valid = 1'b0;
  logic [QW-1:0] tx_vc = '0;
  logic [15:0]   tx_blocks = '0;
  logic          query_valid = 1'b0;
  logic [QW-1:0] query_vc = '0;
  logic          resp_valid;
  logic [SW-1:0] resp_credit;
  logic [QW-1:0] resp_vc;
  logic          init_done;
  logic [SW-1:0] stat_fcp_accepted, stat_fcp_dropped, stat_fcp_stale;

  fcp_credit_tracker #(.QUEUE_INDEX_WIDTH(QW), .STAT_WIDTH(SW), .AXIS_WIDTH(AW), .NUM_VC(NV)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_fcp_tdata(s_axis_fcp_tdata), .s_axis_fcp_tvalid(s_axis_fcp_tvalid),
    .s_axis_fcp_tready(s_axis_fcp_tready),
    .tx_valid(tx_valid), .tx_vc(tx_vc), .tx_blocks(tx_blocks),
    .query_valid(query_valid), .query_vc(query_vc),
    .resp_valid(resp_valid), .resp_credit(resp_credit), .resp_vc(resp_vc),
    .init_done(init_done),
    .stat_fcp_accepted(stat_fcp_accepted), .stat_fcp_dropped(stat_fcp_dropped),
    .stat_fcp_stale(stat_fcp_stale)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_axis_fcp_tvalid = 1'b0;
    tx_valid          = 1'b0;
    query_valid       = 1'b0;
  endtask

  task automatic drive(input bit fv, input int fvc, input logic [31:0] fccl,
                       input bit tv, input int tvc, input int tb,
                       input bit qv, input int qvc);
    s_axis_fcp_tvalid       = fv;
    s_axis_fcp_tdata        = '0;
    s_axis_fcp_tdata[31:0]  = fccl;
    s_axis_fcp_tdata[63:32] = $urandom;
    s_axis_fcp_tdata[95:64] = $urandom;
    s_axis_fcp_tdata[96 +: QW] = QW'(fvc);
    tx_valid    = tv;
    tx_vc       = QW'(tvc);
    tx_blocks   = 16'(tb);
    query_valid = qv;
    query_vc    = QW'(qvc);
  endtask

  // Outputs must be silent during the clear sweep, then come up exactly NV cycles after release.
  task automatic init_check(input string tag);
    int errs;
    errs = 0;
    drive(1'b1, 2, 32'd500, 1'b1, 2, 7, 1'b1, 2);
    for (int i = 0; i < NV; i++) begin
      if (s_axis_fcp_tready !== 1'b0 || init_done !== 1'b0 || resp_valid !== 1'b0) errs++;
      tick();
    end
    idle_inputs();
    chk({tag, "_init_quiet"}, errs, 0);
    chk({tag, "_tready_run"}, s_axis_fcp_tready, 1'b1);
    chk({tag, "_init_done"}, init_done, 1'b1);
    chk({tag, "_acc_after_init"}, stat_fcp_accepted, 0);
    chk({tag, "_drop_after_init"}, stat_fcp_dropped, 0);
  endtask

  typedef struct {
    bit fv; int fvc; logic [31:0] fccl;
    bit tv; int tvc; int tb;
    bit qv; int qvc;
    bit ev; logic [31:0] ec;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  logic [31:0] m_fccl [NV];
  logic [31:0] m_tx   [NV];
  bit          m_val  [NV];
  int          m_acc, m_stale, m_drop;

  function automatic logic [31:0] m_credit(input int vc);
    int d;
    if (vc >= NV || !m_val[vc]) return 0;
    d = int'(m_fccl[vc] - m_tx[vc]);
    return (d < 0) ? 32'd0 : 32'(d);
  endfunction

  initial begin
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", s_axis_fcp_tready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_credit", resp_credit, 0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_stale", stat_fcp_stale, 0);
    rst_n = 1'b1;
    init_check("boot");

    // fv fvc fccl tv tvc tb qv qvc ev ec
    vecs.push_back('{0, 0, 0,            0, 0, 0,  1, 5,   1, 0});
    vecs.push_back('{1, 3, 100,          0, 0, 0,  0, 0,   0, 0});
    vecs.push_back('{0, 0, 0,            1, 3, 30, 0, 0,   0, 0});
    vecs.push_back('{0, 0, 0,            0, 0, 0,  1, 3,   1, 70});
    vecs.push_back('{1, 3, 50,           0, 0, 0,  1, 3,   1, 70});
    vecs.push_back('{0, 0, 0,            0, 0, 0,  1, 3,   1, 70});
    vecs.push_back('{1, 64, 999,         0, 0, 0,  1, 64,  1, 0});
    vecs.push_back('{1, 7, 200,          1, 7, 50, 1, 7,   1, 0});
    vecs.push_back('{0, 0, 0,            0, 0, 0,  1, 7,   1, 150});
    vecs.push_back('{1, 9, 10,           0, 0, 0,  0, 0,   0, 0});
    vecs.push_back('{0, 0, 0,            1, 9, 20, 0, 0,   0, 0});
    vecs.push_back('{0, 0, 0,            0, 0, 0,  1, 9,   1, 0});
    vecs.push_back('{1, 11, 32'hFFFFFFF0, 0, 0, 0, 0, 0,   0, 0});
    vecs.push_back('{1, 11, 32'h10,      0, 0, 0,  0, 0,   0, 0});
    vecs.push_back('{0, 0, 0,            1, 11, 8, 1, 11,  1, 32'h10});
    vecs.push_back('{0, 0, 0,            0, 0, 0,  1, 11,  1, 8});
    vecs.push_back('{0, 0, 0,            1, 100, 5, 1, 3,  1, 70});
    vecs.push_back('{0, 0, 0,            0, 0, 0,  0, 0,   0, 0});

    foreach (vecs[i]) begin
      drive(vecs[i].fv, vecs[i].fvc, vecs[i].fccl, vecs[i].tv, vecs[i].tvc, vecs[i].tb,
            vecs[i].qv, vecs[i].qvc);
      tick();
      chk($sformatf("vec%0d_valid", i), resp_valid, vecs[i].ev);
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_credit", i), resp_credit, vecs[i].ec);
        chk($sformatf("vec%0d_vc", i), resp_vc, QW'(vecs[i].qvc));
      end
    end
    idle_inputs();
    chk("tbl_accepted", stat_fcp_accepted, 5);
    chk("tbl_stale", stat_fcp_stale, 1);
    chk("tbl_dropped", stat_fcp_dropped, 1);

    // Fresh start for the randomized phase so the model begins from a cleared table.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    init_check("rnd");
    for (int v = 0; v < NV; v++) begin
      m_fccl[v] = 0; m_tx[v] = 0; m_val[v] = 0;
    end
    m_acc = 0; m_stale = 0; m_drop = 0;

    for (int c = 0; c < 3000; c++) begin
      bit fv, tv, qv;
      int fvc, tvc, qvc, tb;
      logic [31:0] fccl, exp_cr;
      fv  = ($urandom_range(0, 2) != 0);
      fvc = $urandom_range(0, 70);
      if (fvc < NV && m_val[fvc] && $urandom_range(0, 3) != 0)
        fccl = m_fccl[fvc] + 32'($urandom_range(0, 300)) - 32'd100;
      else if ($urandom_range(0, 1) == 1)
        fccl = 32'hFFFFFF00 + 32'($urandom_range(0, 255));
      else
        fccl = $urandom;
      tv  = ($urandom_range(0, 1) == 1);
      tvc = $urandom_range(0, 70);
      tb  = ($urandom_range(0, 30) == 0) ? 65535 : $urandom_range(0, 40);
      qv  = ($urandom_range(0, 1) == 1);
      qvc = (fv && $urandom_range(0, 1) == 1) ? fvc : $urandom_range(0, 70);
      drive(fv, fvc, fccl, tv, tvc, tb, qv, qvc);
      exp_cr = m_credit(qvc);
      tick();
      chk("rnd_valid", resp_valid, qv);
      if (qv) begin
        chk("rnd_credit", resp_credit, exp_cr);
        chk("rnd_vc", resp_vc, QW'(qvc));
      end
      if (fv) begin
        if (fvc >= NV) m_drop++;
        else if (m_val[fvc] && int'(fccl - m_fccl[fvc]) < 0) m_stale++;
        else begin
          m_fccl[fvc] = fccl;
          m_val[fvc]  = 1;
          m_acc++;
        end
      end
      if (tv && tvc < NV) m_tx[tvc] = m_tx[tvc] + 32'(tb);
    end
    idle_inputs();
    tick();
    chk("rnd_accepted", stat_fcp_accepted, m_acc);
    chk("rnd_stale", stat_fcp_stale, m_stale);
    chk("rnd_dropped", stat_fcp_dropped, m_drop);

    // Asynchronous reset in the middle of traffic.
    drive(1'b1, 4, 32'd1000, 1'b1, 4, 3, 1'b1, 4);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_tready", s_axis_fcp_tready, 1'b0);
    chk("mid_resp_valid", resp_valid, 1'b0);
    chk("mid_init_done", init_done, 1'b0);
    chk("mid_accepted", stat_fcp_accepted, 0);
    chk("mid_stale", stat_fcp_stale, 0);
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    init_check("mid");
    for (int v = 0; v < NV; v++) begin
      if (m_val[v]) begin
        drive(0, 0, 0, 0, 0, 0, 1'b1, v);
        tick();
        chk("mid_cleared_credit", resp_credit, 0);
        chk("mid_cleared_valid", resp_valid, 1'b1);
        break;
      end
    end
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fcp_credit_tracker.md
Name: fcp_credit_tracker

Overview:
- Consumes the packed FCP AXIS stream produced by the FCP source adapter.
- Unpacks each word and maintains a per-VC credit table holding the latest credit limit (FCCL) and the local transmitted-block count.
- Answers credit-available queries from the transmit scheduler, one cycle after each query.
- Sits between the FCP receive path and the per-VC TX scheduler.

Parameters:
- QUEUE_INDEX_WIDTH, 15, width of the VC field in the AXIS word.
- STAT_WIDTH, 32, width of FCCL/QLEN/FCCR, tx counters and credit.
- AXIS_WIDTH, 128, FCP AXIS data width; must be >= 96+QUEUE_INDEX_WIDTH.
- NUM_VC, 64, number of table entries; a power of 2, at most 2^QUEUE_INDEX_WIDTH.

Ports:
- clk  input  1  sole clock.
- rst_n  input  1  asynchronous active-low reset.
- s_axis_fcp_tdata  input  AXIS_WIDTH  packed FCP word: FCCL [31:0], QLEN [63:32], FCCR [95:64], VC [96+:QUEUE_INDEX_WIDTH].
- s_axis_fcp_tvalid  input  1  FCP word valid.
- s_axis_fcp_tready  output  1  tracker can accept a word.
- tx_valid  input  1  transmit event.
- tx_vc  input  QUEUE_INDEX_WIDTH  VC charged by the transmit event.
- tx_blocks  input  16  blocks sent in this event.
- query_valid  input  1  credit query request.
- query_vc  input  QUEUE_INDEX_WIDTH  VC to query.
- resp_valid  output  1  response valid.
- resp_credit  output  STAT_WIDTH  available credit for the queried VC.
- resp_vc  output  QUEUE_INDEX_WIDTH  VC the response refers to.
- init_done  output  1  table clear complete.
- stat_fcp_accepted  output  STAT_WIDTH  FCP words applied to the table.
- stat_fcp_dropped  output  STAT_WIDTH  FCP words dropped (VC out of range).
- stat_fcp_stale  output  STAT_WIDTH  FCP words ignored as stale.

Behaviour:
- Reset: all outputs 0; FSM enters INIT; every counter 0.
- FSM INIT: sweeps index 0..NUM_VC-1, one entry per cycle, clearing fccl, tx_count and the entry valid flag. INIT lasts exactly NUM_VC cycles, then RUN.
- In INIT: s_axis_fcp_tready=0, tx and query inputs ignored, resp_valid=0, init_done=0.
- FSM RUN: s_axis_fcp_tready=1 every cycle; init_done=1. RUN is left only by reset.
- Reset asserted mid-operation: immediate asynchronous clear; INIT restarts from index 0 after release.
- Accept (RUN, tvalid=1): VC = tdata[96+:QUEUE_INDEX_WIDTH]; FCCL = tdata[31:0]; QLEN and FCCR are ignored.
  - VC >= NUM_VC: word dropped, stat_fcp_dropped +1, table untouched.
  - Entry valid and (FCCL − stored_fccl) is negative when read as a signed STAT_WIDTH value: word is stale; stat_fcp_stale +1, table untouched.
  - Otherwise: stored_fccl = FCCL, valid = 1, stat_fcp_accepted +1.
  - The write takes effect at the accepting clock edge.
- Transmit (RUN, tx_valid=1, tx_vc < NUM_VC): tx_count[vc] += tx_blocks, zero-extended, modulo 2^STAT_WIDTH. tx_vc out of range is ignored.
- FCP update and tx event to the same VC in the same cycle: both applied in that cycle.
- Credit = stored_fccl − tx_count, modulo 2^STAT_WIDTH. The result is clamped to 0 when the entry is invalid or when the difference is negative as a signed value.
- Query: a query sampled in cycle N gives resp_valid=1 in cycle N+1 with resp_vc and resp_credit. resp_credit reflects table state before any update or tx sampled in cycle N; read-before-write.
- Query with query_vc >= NUM_VC: response in N+1 with credit 0.
- One query per cycle, no backpressure. resp_valid is a single-cycle pulse per query.
- Stat counters wrap at 2^STAT_WIDTH.
- All arithmetic is modular with wrap-safe signed comparison, so FCCL wrap-around past 2^32 is handled correctly.

Test Plan:
- Reset, NUM_VC=64 -> tready=0 and init_done=0 for exactly 64 cycles after rst_n rises, then tready=1 and init_done=1. A query to VC 5 then returns credit 0.
- FCP VC=3, FCCL=100; next cycle tx VC=3, blocks=30; next cycle query VC=3 -> resp_credit=70 one cycle later. stat_fcp_accepted=1.
- FCP VC=3, FCCL=50 following FCCL=100 -> stat_fcp_stale=1; credit still computed from 100. Then FCCL=0x0000_0010 after FCCL=0xFFFF_FFF0 -> accepted (wrap), table holds 0x10.
- FCP VC=64 (NUM_VC=64) -> stat_fcp_dropped=1; no entry changes. A query to VC 64 returns credit 0.
- Same cycle: FCP VC=7 FCCL=200, tx VC=7 blocks=50, query VC=7 -> response shows the old credit (0). A query the next cycle shows 150.
- tx_count exceeding FCCL (FCCL=10, tx 20) -> credit 0. Assert rst_n mid-stream -> outputs 0 immediately and INIT reruns.
